// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes,
// FSM state encoding and the latency counter width.
package dmem_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    // funct3 codes with no defined load/store meaning
    function automatic logic size_reserved(input logic [2:0] size);
        return (size == 3'b011) || (size == 3'b110) || (size == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channels between the core's memory stage (master) and
// the data-memory responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// DEPTH x 32-bit word storage with per-byte write enables and a registered
// read port. Contents are never reset.
module dmem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // byte-lane writes and read capture on the same edge
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, performs it after LATENCY
// cycles on an internal word array, and returns data/status on a separate
// response channel. Define DMEM_MISALIGN_TRAP_EN to fault misaligned and
// reserved-size accesses; otherwise addresses are aligned down silently.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              accept, access;

    logic              r_we;
    logic [2:0]        r_size;
    logic [1:0]        r_lane;
    logic [AW-1:0]     r_idx;
    logic [31:0]       r_wdata;
    logic              err_q;

    logic              a_we;
    logic [2:0]        a_size;
    logic [1:0]        a_lane;
    logic [AW-1:0]     a_idx;
    logic [31:0]       a_wdata;
    logic              a_err;
    logic [3:0]        a_be;
    logic [31:0]       a_wlane;

    logic [3:0]        arr_be;
    logic              arr_re;
    logic [31:0]       rd;
    logic [31:0]       ext;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    logic              unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:AW+2];

    // state, countdown and captured request fields
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            r_we    <= 1'b0;
            r_size  <= '0;
            r_lane  <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                r_we    <= bus.req_we;
                r_size  <= bus.req_size;
                r_lane  <= bus.req_addr[1:0];
                r_idx   <= bus.req_addr[AW+1:2];
                r_wdata <= bus.req_wdata;
            end
            if (access) begin
                err_q <= a_err;
            end
        end
    end

    // next state, handshake outputs and the access strobe
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        accept        = 1'b0;
        access        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (LATENCY <= 1) begin
                        state_nx = S_RESP;
                        access   = 1'b1;
                    end else begin
                        state_nx = S_BUSY;
                        cnt_nx   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_BUSY: begin
                if (cnt == '0) begin
                    state_nx = S_RESP;
                    access   = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // access fields: live inputs when the access coincides with accept
    // (LATENCY=1), otherwise the copy captured at accept
    always_comb begin
        if (state == S_IDLE) begin
            a_we    = bus.req_we;
            a_size  = bus.req_size;
            a_lane  = bus.req_addr[1:0];
            a_idx   = bus.req_addr[AW+1:2];
            a_wdata = bus.req_wdata;
        end else begin
            a_we    = r_we;
            a_size  = r_size;
            a_lane  = r_lane;
            a_idx   = r_idx;
            a_wdata = r_wdata;
        end
    end

    // fault detection for the access about to be performed
    always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
        a_err = size_reserved(a_size)
             || (a_size[1:0] == 2'b01 && a_lane[0])
             || (a_size[1:0] == 2'b10 && a_lane != 2'b00);
`else
        a_err = 1'b0;
`endif
    end

    // store lane steering: replicate data across lanes, enable addressed bytes
    always_comb begin
        a_be    = '0;
        a_wlane = '0;
        if (a_we && !a_err) begin
            unique case (a_size[1:0])
                2'b00: begin
                    a_be    = 4'b0001 << a_lane;
                    a_wlane = {4{a_wdata[7:0]}};
                end
                2'b01: begin
                    a_be    = a_lane[1] ? 4'b1100 : 4'b0011;
                    a_wlane = {2{a_wdata[15:0]}};
                end
                default: begin
                    a_be    = '1;
                    a_wlane = a_wdata;
                end
            endcase
        end
    end

    assign arr_be = access ? a_be : '0;
    assign arr_re = access && !a_we;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .be    (arr_be),
        .re    (arr_re),
        .idx   (a_idx),
        .wdata (a_wlane),
        .rdata (rd)
    );

    // load lane extraction and sign/zero extension from the captured word
    always_comb begin
        rd_byte = 8'(rd >> {r_lane, 3'b000});
        rd_half = r_lane[1] ? rd[31:16] : rd[15:0];
        unique case (r_size[1:0])
            2'b00:   ext = r_size[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   ext = r_size[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ext = rd;
        endcase
    end

    // the read register only changes on an access edge, so these stay
    // stable for the whole RESP interval
    assign bus.rsp_rdata = (state == S_RESP && !r_we && !err_q) ? ext : '0;
    assign bus.rsp_err   = (state == S_RESP) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a reference memory model predicts
// each response when the request is driven; a monitor pops and compares on
// every response handshake. Honours DMEM_MISALIGN_TRAP_EN like the design.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned TMO   = 50;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    exp_t        sb[$];
    logic [31:0] mdl [DEPTH];

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: applies stores, predicts load data and fault status
    function automatic exp_t model(input logic we, input logic [2:0] size,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [9:0]  idx;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        idx     = addr[11:2];
        w       = mdl[idx];
        e.err   = 1'b0;
        e.rdata = '0;
`ifdef DMEM_MISALIGN_TRAP_EN
        e.err = (size == 3'b011) || (size == 3'b110) || (size == 3'b111)
             || ((size == SZ_H || size == SZ_HU) && addr[0])
             || (size == SZ_W && addr[1:0] != 2'b00);
`endif
        if (!e.err) begin
            case (addr[1:0])
                2'd0: b = w[7:0];
                2'd1: b = w[15:8];
                2'd2: b = w[23:16];
                default: b = w[31:24];
            endcase
            h = addr[1] ? w[31:16] : w[15:0];
            if (we) begin
                case (size)
                    SZ_B: mdl[idx][8*addr[1:0] +: 8] = wdata[7:0];
                    SZ_H: if (addr[1]) mdl[idx][31:16] = wdata[15:0];
                          else         mdl[idx][15:0]  = wdata[15:0];
                    default: mdl[idx] = wdata;
                endcase
            end else begin
                case (size)
                    SZ_B:    e.rdata = {{24{b[7]}}, b};
                    SZ_BU:   e.rdata = {24'h0, b};
                    SZ_H:    e.rdata = {{16{h[15]}}, h};
                    SZ_HU:   e.rdata = {16'h0, h};
                    default: e.rdata = w;
                endcase
            end
        end
        return e;
    endfunction

    // compare every response handshake against the scoreboard head
    always @(negedge clk) begin
        if (reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
            end
        end
    end

    // one full transaction; hold>0 keeps rsp_ready low that many cycles
    task automatic xact(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int unsigned hold);
        exp_t        e;
        int unsigned n;
        int unsigned acc;
        e = model(we, size, addr, wdata);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.rsp_ready = (hold == 0);
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", {31'h0, bus.req_ready}, 32'd1);
            return;
        end
        acc = cyc + 1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) begin
            check("rsp_timeout", {31'h0, bus.rsp_valid}, 32'd1);
            return;
        end
        check("latency", cyc, acc + LAT);
        check("req_ready_in_resp", {31'h0, bus.req_ready}, 32'd0);
        for (int unsigned i = 0; i < hold; i++) begin
            check("bp_valid", {31'h0, bus.rsp_valid}, 32'd1);
            check("bp_rdata", bus.rsp_rdata, e.rdata);
            check("bp_req_ready", {31'h0, bus.req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        check("rsp_valid_after_hs", {31'h0, bus.rsp_valid}, 32'd0);
        check("req_ready_after_hs", {31'h0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        int unsigned n;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = SZ_W;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        #23;
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'h0, bus.rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // known contents for every word the bench reads
        for (int unsigned i = 0; i < 18; i++) begin
            xact(1'b1, SZ_W, 32'(4 * i), 32'h0, 0);
        end

        // store then load
        xact(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 0);
        xact(1'b0, SZ_W, 32'h10, 32'h0, 0);

        // byte store, sign/zero extension; upper wdata bits must be ignored
        xact(1'b1, SZ_B, 32'h21, 32'h12345680, 0);
        xact(1'b0, SZ_B, 32'h21, 32'h0, 0);
        xact(1'b0, SZ_BU, 32'h21, 32'h0, 0);
        xact(1'b0, SZ_W, 32'h20, 32'h0, 0);

        // halfword under back-pressure
        xact(1'b1, SZ_W, 32'h0, 32'h80010000, 0);
        xact(1'b0, SZ_H, 32'h2, 32'h0, 5);
        xact(1'b0, SZ_HU, 32'h2, 32'h0, 0);
        xact(1'b1, SZ_H, 32'h6, 32'hFFFF7E55, 0);
        xact(1'b0, SZ_W, 32'h4, 32'h0, 0);

        // misaligned word store, then observe the aligned word
        xact(1'b1, SZ_W, 32'h13, 32'hCAFEF00D, 0);
        xact(1'b0, SZ_W, 32'h10, 32'h0, 0);
        xact(1'b0, SZ_H, 32'h11, 32'h0, 0);
        xact(1'b0, 3'b111, 32'h10, 32'h0, 0);

        // address wrap
        xact(1'b1, SZ_W, 32'h1000, 32'h12345678, 0);
        xact(1'b0, SZ_W, 32'h0, 32'h0, 0);

        // reset while a store is in BUSY: store must be discarded
        xact(1'b1, SZ_W, 32'h40, 32'h11112222, 0);
        @(posedge clk); #1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_W;
        bus.req_addr  = 32'h40;
        bus.req_wdata = 32'hAAAAAAAA;
        bus.req_valid = 1'b1;
        @(negedge clk);
        check("pre_store_ready", {31'h0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("busy_req_ready", {31'h0, bus.req_ready}, 32'd0);
        #1 reset = 1'b0;
        #1;
        check("rst_busy_req_ready", {31'h0, bus.req_ready}, 32'd1);
        check("rst_busy_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        xact(1'b0, SZ_W, 32'h40, 32'h0, 0);

        // reset while a load response is pending: rsp_valid drops at once
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = SZ_W;
        bus.req_addr  = 32'h10;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("resp_before_rst", {31'h0, bus.rsp_valid}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rst_resp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        check("rst_resp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_resp_ready", {31'h0, bus.req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        xact(1'b0, SZ_W, 32'h40, 32'h0, 0);

        // random mix in the initialised region
        for (int unsigned i = 0; i < 24; i++) begin
            logic        we;
            logic [2:0]  size;
            we   = 1'($urandom);
            size = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            xact(we, size, 32'($urandom_range(0, 31)), $urandom, $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data memory port: it accepts a single load or store request from the execute/memory stage over a valid/ready handshake. It performs the access on an internal word array after a fixed, parameterised latency, then returns read data and a status on a separate valid/ready response channel. It is the slave end of the `aluout`/`writedata`/`readdata` path and lets the pipelined core be tested against non-zero-latency memory.

## Interface
- `DEPTH`, 1024: number of 32-bit words; must be a power of two.
- `LATENCY`, 2: cycles from request accept to `rsp_valid` rising; legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 3: RISC-V funct3 access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: load result, sign- or zero-extended; 0 for stores.
- `rsp_err` out 1: access faulted (see Configuration).

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - BUSY: counts down the remaining latency.
  - RESP: `rsp_valid`=1.
- Transitions:
  - IDLE→BUSY on `req_valid&&req_ready`, loading counter = LATENCY-1. If LATENCY=1, IDLE goes directly to RESP.
  - BUSY→RESP when counter=0; otherwise the counter decrements each cycle.
  - RESP→IDLE on `rsp_valid&&rsp_ready`.
- Request fields are registered on accept. Later changes to `req_*` are ignored until the next accept.
- Word index = `req_addr[31:2]` modulo DEPTH; addresses silently wrap.
- Load extraction:
  - Byte lane `addr[1:0]`; half lane `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores write only the addressed byte lanes. There is no read-modify-write hazard: byte enables are used.
- The array access (read capture or write) happens on the edge that enters RESP. `rsp_rdata` and `rsp_err` are registered on that same edge and held stable while in RESP.
- Memory contents are not reset.

## Timing
- Reset values:
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - FSM=IDLE, counter=0.
- Latency: accept at edge N means `rsp_valid` is high from edge N+LATENCY.
- Minimum occupancy: LATENCY+1 cycles per transaction, because `req_ready` returns high the cycle after the response handshake.
- No overlap: `req_ready`=0 in BUSY and RESP.
  - A request held during those states is accepted on the first IDLE cycle.
- Response back-pressure: `rsp_valid` and `rsp_rdata` must not change while `rsp_ready`=0.
- Asynchronous reset at any point:
  - Immediately forces IDLE and drops `rsp_valid`.
  - An in-flight store that has not reached RESP is discarded.
  - A store already written stays written.
- A load after a store to the same word observes the new data, because transactions are strictly serialised.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses raise `rsp_err`=1: a half with `addr[0]`=1, or a word with `addr[1:0]`≠0.
  - Reserved `req_size` codes (011, 110, 111) also raise `rsp_err`=1.
  - For an erroring access: no array write, `rsp_rdata`=0, and the full latency and handshake still apply.
- Not defined:
  - `rsp_err` is tied 0.
  - Half accesses ignore `addr[0]`; word accesses ignore `addr[1:0]` (aligned down).
  - Reserved size codes are treated as word.

## Structure
- Package `dmem_pkg` holds:
  - funct3 size constants: SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU.
  - FSM state enum: S_IDLE, S_BUSY, S_RESP.
  - The 4-bit latency counter width.
- Sub-module `dmem_array`:
  - DEPTH×32 storage with 4-bit byte write enable.
  - Synchronous write and read, index input.
- The responder owns the FSM, lane steering, extension and error logic.

## Test plan
- Store then load:
  - Stimulus (LATENCY=2): SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10.
  - Response: `rsp_valid` exactly 2 cycles after each accept; load returns 0xDEADBEEF with `rsp_err`=0.
- Byte stores and extension:
  - Stimulus: SB 0x80 to addr 0x21, then LB 0x21, LBU 0x21, LW 0x20 (word previously 0).
  - Response: 0xFFFFFF80, 0x00000080, 0x00008000.
- Response back-pressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles during an LH at addr 0x2 of word 0x8001_0000.
  - Response: `rsp_valid` and `rsp_rdata`=0xFFFF8001 stable throughout; `req_ready`=0 until one cycle after the handshake.
- Misaligned word store with `DMEM_MISALIGN_TRAP_EN`:
  - Stimulus: SW addr 0x13.
  - Response: `rsp_err`=1 and the word at 0x10 unchanged.
  - Without the macro: data lands at 0x10 and `rsp_err`=0.
- Address wrap:
  - Stimulus (DEPTH=1024): SW addr 0x1000 data 0x12345678, then LW addr 0x0.
  - Response: 0x12345678.
- Reset mid-store:
  - Stimulus: assert `reset`=0 while in BUSY of SW addr 0x40 data 0xAAAAAAAA.
  - Response: `rsp_valid` falls immediately; after release, LW 0x40 returns the old value; `req_ready`=1 during reset.
